// File: rtl/branch_unit_if.sv
// Bundle between the ALU/decode stage and the branch unit: flags, branch request, fetch/link results.
interface branch_unit_if;
  logic        stall;
  logic        halt;
  logic        alu_neg;
  logic        alu_zero;
  logic        alu_carry;
  logic        flag_we;
  logic        br_en;
  logic [2:0]  br_op;
  logic [31:0] br_target;
  logic [31:0] rs_val;
  logic [31:0] pc;
  logic        taken;
  logic        flush;
  logic        link_we;
  logic [31:0] link_data;
  logic        neg_q;
  logic        zero_q;
  logic        carry_q;
  logic        halted;

  modport master (
    output stall, halt, alu_neg, alu_zero, alu_carry, flag_we,
           br_en, br_op, br_target, rs_val,
    input  pc, taken, flush, link_we, link_data, neg_q, zero_q, carry_q, halted
  );

  modport slave (
    input  stall, halt, alu_neg, alu_zero, alu_carry, flag_we,
           br_en, br_op, br_target, rs_val,
    output pc, taken, flush, link_we, link_data, neg_q, zero_q, carry_q, halted
  );
endinterface

// File: rtl/branch_unit.sv
// KGP-RISC control-flow stage: flag register, branch condition evaluation,
// program counter, link writeback and single-slot wrong-path squash.
module branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input logic          clk,
  input logic          rst,
  branch_unit_if.slave bus
);

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] OP_B    = 3'd0;
  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_BLTZ = 3'd2;
  localparam logic [2:0] OP_BZ   = 3'd3;
  localparam logic [2:0] OP_BNZ  = 3'd4;
  localparam logic [2:0] OP_BL   = 3'd5;
  localparam logic [2:0] OP_BCY  = 3'd6;
  localparam logic [2:0] OP_BNCY = 3'd7;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            neg_q, neg_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;

  logic            cond;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;

  assign pc_inc = pc_q + XLEN'(PC_STEP);

  // Branch condition and raw target; BCY/BNCY see the carry captured in an earlier cycle.
  always_comb begin
    cond   = 1'b0;
    target = bus.br_target;
    case (bus.br_op)
      OP_B:    cond = 1'b1;
      OP_BR: begin
        cond   = 1'b1;
        target = bus.rs_val;
      end
      OP_BLTZ: cond = bus.rs_val[XLEN-1];
      OP_BZ:   cond = (bus.rs_val == '0);
      OP_BNZ:  cond = (bus.rs_val != '0);
      OP_BL:   cond = 1'b1;
      OP_BCY:  cond = carry_q;
      OP_BNCY: cond = ~carry_q;
      default: cond = 1'b0;
    endcase
  end

  assign taken = bus.br_en & cond & (state_q == ST_RUN) & ~bus.stall;

  // Next-state, next-pc and flag capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    case (state_q)
      ST_RUN: begin
        if (!bus.stall) begin
          if (bus.flag_we) begin
            neg_d   = bus.alu_neg;
            zero_d  = bus.alu_zero;
            carry_d = bus.alu_carry;
          end
          if (bus.halt) begin
            state_d = ST_HALT;
          end else if (taken) begin
            pc_d    = target & ~XLEN'(3);
            state_d = ST_FLUSH;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      ST_FLUSH: begin
        if (!bus.stall) begin
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.taken     = taken;
  assign bus.flush     = (state_q == ST_FLUSH);
  assign bus.halted    = (state_q == ST_HALT);
  assign bus.link_we   = taken & (bus.br_op == OP_BL);
  assign bus.link_data = bus.link_we ? pc_inc : '0;
  assign bus.neg_q     = neg_q;
  assign bus.zero_q    = zero_q;
  assign bus.carry_q   = carry_q;

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
Control-flow stage directly downstream of the ALU. It consumes the ALU's neg/zero/carry flags and holds them in a flag register. It evaluates the eight KGP-RISC branch conditions, owns the program counter, and produces the next fetch address. On a call it also produces link-register writeback data, and after every taken branch it squashes the one wrong-path instruction already in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment per sequential instruction

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold all state this cycle
halt  input  1  request to stop fetching
alu_neg  input  1  ALU negative flag
alu_zero  input  1  ALU zero flag
alu_carry  input  1  ALU carry flag
flag_we  input  1  capture ALU flags at end of this cycle
br_en  input  1  current instruction is a branch
br_op  input  3  branch opcode (see Behaviour)
br_target  input  32  absolute target for B/BL
rs_val  input  32  register operand for BR/BLTZ/BZ/BNZ
pc  output  32  current fetch address (registered)
taken  output  1  branch taken this cycle (combinational)
flush  output  1  squash the instruction currently in decode (registered)
link_we  output  1  write link register this cycle (combinational)
link_data  output  32  pc+PC_STEP when link_we=1, else 0
neg_q  output  1  registered neg flag
zero_q  output  1  registered zero flag
carry_q  output  1  registered carry flag
halted  output  1  high while in HALT

Behaviour:
- Reset (rst=1 at posedge, overrides everything including stall/halt): pc=RESET_PC, flags=0, state=RUN, flush=0, halted=0. Reset mid-FLUSH or mid-HALT returns to RUN.
- br_op encoding and taken condition:
  - 0 B: always, target br_target
  - 1 BR: always, target rs_val
  - 2 BLTZ: rs_val[31]=1, target br_target
  - 3 BZ: rs_val==0, target br_target
  - 4 BNZ: rs_val!=0, target br_target
  - 5 BL: always, target br_target, link
  - 6 BCY: carry_q=1, target br_target
  - 7 BNCY: carry_q=0, target br_target
- Target bits [1:0] are forced to 00 when loaded into pc.
- taken = br_en & cond & state==RUN & !stall.
- link_we = taken & br_op==5.
- link_data = pc+PC_STEP, modulo 2^32.
- States:
  - RUN:
    - stall=1: hold everything.
    - else if halt=1: go to HALT with pc held; a branch in the same cycle is ignored.
    - else if taken: pc<=target and go to FLUSH.
    - else: pc<=pc+PC_STEP.
    - Flags are updated when flag_we=1 and stall=0.
  - FLUSH:
    - flush=1 for exactly this cycle.
    - br_en and flag_we are ignored, because the squashed instruction has no effect.
    - With stall=0: pc<=pc+PC_STEP, then go to RUN.
    - With stall=1: hold, and flush stays 1.
  - HALT: pc, flags and state are frozen; halted=1. Only rst exits.
- Simultaneous flag_we and BCY/BNCY: the condition uses the OLD carry_q; the new flags become visible the next cycle.
- PC wrap: 32'hFFFF_FFFC + 4 becomes 32'h0000_0000 with no error.
- Flags are plain registers, not recomputed; neg_q, zero_q and carry_q always mirror the last captured ALU values.

Test Plan:
- Reset with RESET_PC=0, then 3 cycles with br_en=0 -> pc=0,4,8,12; flush=0; flags=0.
- pc=0x10, br_en=1, op=5, target=0x103 -> taken=1, link_we=1, link_data=0x14. Next cycle pc=0x100, flush=1. The following cycle pc=0x104, flush=0.
- alu_carry=1 with flag_we=1 and BCY issued the same cycle -> taken=0 (old carry_q=0). Repeat BCY the next cycle -> taken=1.
- BLTZ with rs_val=0xFFFFFFCA -> taken. BZ with rs_val=0 -> taken. BNZ with rs_val=0 -> not taken and pc+4. BR with rs_val=0x40 -> pc=0x40.
- During FLUSH, drive br_en=1, op=0, target=0x200, plus flag_we=1 with alu_zero=1 -> no branch, zero_q unchanged. Stall held 2 cycles in FLUSH -> pc held and flush stays 1.
- halt=1 at pc=0x20 -> halted=1 with pc stuck at 0x20 for 5 cycles. Then rst=1 -> pc=0 and RUN. Also pc=0xFFFFFFFC with no branch -> next pc=0.
